// File: rtl/cphy_afe_pkg.sv
// Shared definitions for the C-PHY receiver AFE model and its neighbours.
package cphy_afe_pkg;

  // Mode encoding is visible on the Mode port and shared with the slave RX bench.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LP        = 2'd1,
    HS_SETTLE = 2'd2,
    HS        = 2'd3
  } afe_mode_t;

  // Mode requested by the enables alone. An HS request always starts at HS_SETTLE.
  // Settle progress is handled by the caller.
  function automatic afe_mode_t afe_req_mode(input logic hs_en, input logic lp_en);
    if (hs_en) begin
      return HS_SETTLE;
    end else if (lp_en) begin
      return LP;
    end else begin
      return IDLE;
    end
  endfunction

endpackage

// File: rtl/cphy_lp_glitch_filter.sv
// Per-wire LP glitch filter. The filtered level is held by the caller's output
// register (lvl_i). This block owns only the run counter and computes the next level.
module cphy_lp_glitch_filter #(
  parameter int unsigned LP_FILT_CYC = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,   // LP entry edge: take raw directly, clear counter
  input  logic run_i,    // steady LP: apply filter rule
  input  logic raw_i,    // thresholded wire level this edge
  input  logic lvl_i,    // current filtered level (registered by caller)
  output logic lvl_d_o   // filtered level after this edge
);

  localparam int unsigned CntW = $clog2(LP_FILT_CYC + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next level and counter. The counter is cleared whenever the filter is not running.
  always_comb begin
    cnt_d   = '0;
    lvl_d_o = 1'b0;
    if (load_i) begin
      lvl_d_o = raw_i;
    end else if (run_i) begin
      lvl_d_o = lvl_i;
      if (raw_i != lvl_i) begin
        if (cnt_q == CntW'(LP_FILT_CYC - 1)) begin
          lvl_d_o = raw_i;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cphy_rx_afe_model.sv
// Clocked behavioural model of the C-PHY RX analog front end for N_TRIOS trios.
// It produces HS comparator bits after a settle delay, or glitch-filtered LP levels.
module cphy_rx_afe_model
  import cphy_afe_pkg::*;
#(
  parameter int unsigned N_TRIOS       = 1,
  parameter int unsigned WIRE_W        = 8,
  parameter int unsigned LP_THRESH     = 100,
  parameter int unsigned HS_SETTLE_CYC = 4,
  parameter int unsigned LP_FILT_CYC   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_TRIOS*WIRE_W-1:0] A_Wire,
  input  logic [N_TRIOS*WIRE_W-1:0] B_Wire,
  input  logic [N_TRIOS*WIRE_W-1:0] C_Wire,
  input  logic                      HsRxEn,
  input  logic                      LpRxEn,
  output logic [N_TRIOS-1:0]        A,
  output logic [N_TRIOS-1:0]        B,
  output logic [N_TRIOS-1:0]        C,
  output logic                      Hs_Valid,
  output logic                      Lp_Valid,
  output logic [1:0]                Mode
);

  localparam int unsigned SetW = $clog2(HS_SETTLE_CYC + 1);
  localparam logic [WIRE_W-1:0] LpThresh = WIRE_W'(LP_THRESH);

  afe_mode_t         mode_q, mode_d;
  logic [SetW-1:0]   settle_q, settle_d;
  logic [N_TRIOS-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic              hs_valid_q, hs_valid_d, lp_valid_q, lp_valid_d;

  logic [N_TRIOS-1:0] cmp_ab, cmp_bc, cmp_ca;
  logic [N_TRIOS-1:0] raw_a, raw_b, raw_c;
  logic [N_TRIOS-1:0] lp_a, lp_b, lp_c;
  logic               lp_load, lp_run;

  // Mode FSM next state. Dropping HsRxEn leaves the HS path on the same edge.
  // Any fresh HS request restarts settle from zero.
  always_comb begin
    mode_d   = afe_req_mode(HsRxEn, LpRxEn);
    settle_d = '0;
    unique case (mode_q)
      HS_SETTLE: begin
        if (HsRxEn) begin
          if (settle_q == SetW'(HS_SETTLE_CYC - 1)) begin
            mode_d = HS;
          end else begin
            settle_d = settle_q + SetW'(1);
          end
        end
      end
      HS: begin
        if (HsRxEn) begin
          mode_d = HS;
        end
      end
      default: ;
    endcase
  end

  // LP entry loads raw levels. Staying in LP runs the filters.
  assign lp_load = (mode_d == LP) && (mode_q != LP);
  assign lp_run  = (mode_d == LP) && (mode_q == LP);

  // Per-trio comparators, thresholds and LP filters.
  for (genvar t = 0; t < N_TRIOS; t++) begin : g_trio
    logic [WIRE_W-1:0] code_a, code_b, code_c;

    assign code_a = A_Wire[t*WIRE_W +: WIRE_W];
    assign code_b = B_Wire[t*WIRE_W +: WIRE_W];
    assign code_c = C_Wire[t*WIRE_W +: WIRE_W];

    // Strict compares: ties resolve to 0.
    assign cmp_ab[t] = code_a > code_b;
    assign cmp_bc[t] = code_b > code_c;
    assign cmp_ca[t] = code_c > code_a;

    assign raw_a[t] = code_a >= LpThresh;
    assign raw_b[t] = code_b >= LpThresh;
    assign raw_c[t] = code_c >= LpThresh;

    cphy_lp_glitch_filter #(
      .LP_FILT_CYC (LP_FILT_CYC)
    ) u_filt_a (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (lp_load),
      .run_i   (lp_run),
      .raw_i   (raw_a[t]),
      .lvl_i   (a_q[t]),
      .lvl_d_o (lp_a[t])
    );

    cphy_lp_glitch_filter #(
      .LP_FILT_CYC (LP_FILT_CYC)
    ) u_filt_b (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (lp_load),
      .run_i   (lp_run),
      .raw_i   (raw_b[t]),
      .lvl_i   (b_q[t]),
      .lvl_d_o (lp_b[t])
    );

    cphy_lp_glitch_filter #(
      .LP_FILT_CYC (LP_FILT_CYC)
    ) u_filt_c (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (lp_load),
      .run_i   (lp_run),
      .raw_i   (raw_c[t]),
      .lvl_i   (c_q[t]),
      .lvl_d_o (lp_c[t])
    );
  end

  // Output next values follow the mode being entered, so outputs and Mode change together.
  always_comb begin
    a_d        = '0;
    b_d        = '0;
    c_d        = '0;
    hs_valid_d = 1'b0;
    lp_valid_d = 1'b0;
    unique case (mode_d)
      HS: begin
        a_d        = cmp_ab;
        b_d        = cmp_bc;
        c_d        = cmp_ca;
        hs_valid_d = 1'b1;
      end
      LP: begin
        a_d        = lp_a;
        b_d        = lp_b;
        c_d        = lp_c;
        lp_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= IDLE;
      settle_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      hs_valid_q <= 1'b0;
      lp_valid_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      settle_q   <= settle_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      hs_valid_q <= hs_valid_d;
      lp_valid_q <= lp_valid_d;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign C        = c_q;
  assign Hs_Valid = hs_valid_q;
  assign Lp_Valid = lp_valid_q;
  assign Mode     = mode_q;

endmodule

// File: tb/tb_cphy_rx_afe_model.sv
// Scoreboard bench for cphy_rx_afe_model. A reference model predicts each edge,
// and a monitor compares the prediction one delta after that edge.
module tb_cphy_rx_afe_model;

  localparam int NT   = 2;
  localparam int WW   = 8;
  localparam int TH   = 100;
  localparam int SET  = 4;
  localparam int FILT = 3;
  localparam int NW   = NT * 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [NT*WW-1:0] a_wire, b_wire, c_wire;
  logic           hs_en, lp_en;
  logic [NT-1:0]  a_o, b_o, c_o;
  logic           hs_v, lp_v;
  logic [1:0]     mode_o;

  cphy_rx_afe_model #(
    .N_TRIOS       (NT),
    .WIRE_W        (WW),
    .LP_THRESH     (TH),
    .HS_SETTLE_CYC (SET),
    .LP_FILT_CYC   (FILT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .A_Wire   (a_wire),
    .B_Wire   (b_wire),
    .C_Wire   (c_wire),
    .HsRxEn   (hs_en),
    .LpRxEn   (lp_en),
    .A        (a_o),
    .B        (b_o),
    .C        (c_o),
    .Hs_Valid (hs_v),
    .Lp_Valid (lp_v),
    .Mode     (mode_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          mode;
    logic [NT-1:0] a, b, c;
    logic        hv, lv;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: codes indexed trio*3 + wire (0=A, 1=B, 2=C).
  int          cur [NW];
  int          m_mode;    // 0 idle, 1 lp, 2 settle, 3 hs
  int          hs_run;    // consecutive edges with HsRxEn high
  logic        lvl [NW];  // filtered LP level per wire
  logic [31:0] hist [NW]; // LP samples since entry / last flip, newest in bit 0
  int          hlen [NW];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = 0;
    hs_run = 0;
    for (int w = 0; w < NW; w++) begin
      lvl[w]  = 1'b0;
      hist[w] = '0;
      hlen[w] = 0;
    end
  endtask

  // Predict the outputs after the coming edge from the inputs now applied.
  task automatic model_edge();
    exp_t e;
    e.mode = 0; e.a = '0; e.b = '0; e.c = '0; e.hv = 1'b0; e.lv = 1'b0;
    if (hs_en) begin
      hs_run++;
      if (hs_run > SET) begin
        m_mode = 3;
        e.hv = 1'b1;
        for (int t = 0; t < NT; t++) begin
          e.a[t] = cur[3*t]   > cur[3*t+1];
          e.b[t] = cur[3*t+1] > cur[3*t+2];
          e.c[t] = cur[3*t+2] > cur[3*t];
        end
      end else begin
        m_mode = 2;
      end
    end else begin
      hs_run = 0;
      if (lp_en) begin
        for (int w = 0; w < NW; w++) begin
          logic raw;
          raw = (cur[w] >= TH);
          if (m_mode != 1) begin
            lvl[w]  = raw;
            hlen[w] = 0;
          end else begin
            int  tr;
            bit  stop;
            hist[w] = {hist[w][30:0], raw};
            if (hlen[w] < 32) hlen[w]++;
            tr = 0; stop = 1'b0;
            for (int i = 0; i < hlen[w]; i++) begin
              if (!stop) begin
                if (hist[w][i] != lvl[w]) tr++;
                else stop = 1'b1;
              end
            end
            if (tr >= FILT) begin
              lvl[w]  = raw;
              hlen[w] = 0;
            end
          end
        end
        m_mode = 1;
        e.lv = 1'b1;
        for (int t = 0; t < NT; t++) begin
          e.a[t] = lvl[3*t];
          e.b[t] = lvl[3*t+1];
          e.c[t] = lvl[3*t+2];
        end
      end else begin
        m_mode = 0;
      end
    end
    e.mode = m_mode;
    sb.push_back(e);
  endtask

  task automatic pack_wires();
    for (int t = 0; t < NT; t++) begin
      a_wire[t*WW +: WW] = WW'(cur[3*t]);
      b_wire[t*WW +: WW] = WW'(cur[3*t+1]);
      c_wire[t*WW +: WW] = WW'(cur[3*t+2]);
    end
  endtask

  task automatic step(input logic hs, input logic lp);
    @(negedge clk);
    hs_en = hs;
    lp_en = lp;
    pack_wires();
    model_edge();
  endtask

  task automatic set_trio(input int t, input int a, input int b, input int c);
    cur[3*t] = a; cur[3*t+1] = b; cur[3*t+2] = c;
  endtask

  function automatic int rnd_code();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(95, 105));
      1:       return 80;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_mode"}, int'(mode_o), 0);
    check({tag, "_abc"}, int'({a_o, b_o, c_o}), 0);
    check({tag, "_hsv"}, int'(hs_v), 0);
    check({tag, "_lpv"}, int'(lp_v), 0);
  endtask

  // Monitor: the DUT presents a fresh output set after every edge.
  always begin
    @(posedge clk);
    #1;
    if (!rst && sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("mode", int'(mode_o), mon_e.mode);
      check("abc", int'({a_o, b_o, c_o}), int'({mon_e.a, mon_e.b, mon_e.c}));
      check("valids", int'({hs_v, lp_v}), int'({mon_e.hv, mon_e.lv}));
    end
  end

  initial begin
    rst = 1'b1; hs_en = 1'b0; lp_en = 1'b0;
    for (int w = 0; w < NW; w++) cur[w] = 0;
    pack_wires();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // HS entry: settle for SET edges, then compare results.
    set_trio(0, 200, 50, 120);
    set_trio(1, 10, 10, 10);
    repeat (7) step(1'b1, 1'b0);
    // HS ties stay valid with all-zero bits.
    set_trio(0, 80, 80, 80);
    set_trio(1, 30, 90, 60);
    repeat (3) step(1'b1, 1'b0);

    // Asynchronous reset while in HS.
    @(posedge clk);
    #3;
    rst = 1'b1; hs_en = 1'b0; lp_en = 1'b0;
    #1;
    check_reset_state("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // LP filter: short glitches are rejected, and a run of FILT glitches gets through.
    set_trio(0, 150, 150, 20);
    set_trio(1, 20, 150, 20);
    step(1'b0, 1'b1);
    cur[0] = 20;  repeat (2) step(1'b0, 1'b1);
    cur[0] = 150; step(1'b0, 1'b1);
    cur[0] = 20;  repeat (4) step(1'b0, 1'b1);

    // LP threshold boundary on entry loads.
    foreach (cur[w]) cur[w] = 0;
    cur[0] = 99;  step(1'b0, 1'b0); step(1'b0, 1'b1);
    cur[0] = 100; step(1'b0, 1'b0); step(1'b0, 1'b1);
    cur[0] = 255; step(1'b0, 1'b0); step(1'b0, 1'b1);

    // A short HS pulse during LP aborts to an LP reload and never reaches HS.
    set_trio(0, 150, 20, 150);
    repeat (2) step(1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b1);
    set_trio(0, 20, 150, 20);
    repeat (4) step(1'b0, 1'b1);

    // Randomised bursts of modes with sticky, threshold-biased wire codes.
    for (int burst = 0; burst < 60; burst++) begin
      int   len;
      int   sel;
      logic hs, lp;
      len = int'($urandom_range(1, 12));
      sel = int'($urandom_range(0, 5));
      hs  = (sel >= 3);
      lp  = (sel == 1) || (sel == 2) || (sel == 4) || (sel == 5 && $urandom_range(0, 1) == 1);
      for (int i = 0; i < len; i++) begin
        for (int w = 0; w < NW; w++) begin
          if ($urandom_range(0, 3) == 0) cur[w] = rnd_code();
        end
        step(hs, lp);
      end
    end
    step(1'b0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    check("drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
